// File: rtl/siso_seq_ctrl.sv
// siso_seq_ctrl: valid/ready sequencer that drives an external DEPTH-stage SISO chain MSB-first
// and reassembles the returning word. Define SISO_LOOPCHK_EN for the sticky loopback compare on err.
module siso_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_si,
  input  logic             sr_so,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + DEPTH + 2);
  localparam logic [CW-1:0] SEND_END  = CW'(WIDTH);
  localparam logic [CW-1:0] WAIT_END  = CW'(DEPTH);
  localparam logic [CW-1:0] CAP_FIRST = CW'(DEPTH + 1);
  localparam logic [CW-1:0] LAST      = CW'(DEPTH + WIDTH);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CAPT, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sh, rx_reg, rx_next;
  logic             accept, capture, done_entry;

  // NOTE: registered state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rs) state <= IDLE;
    else     state <= state_next;
  end

  // cnt holds the edge index n since the accept edge; the label chosen here names the coming cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SEND;
      end
      SEND, WAIT, CAPT: begin
        busy = 1'b1;
        if (cnt == LAST)          state_next = DONE;
        else if (cnt < SEND_END)  state_next = SEND;
        else if (cnt >= WAIT_END) state_next = CAPT;
        else                      state_next = WAIT;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept     = in_ready && in_valid;
  assign capture    = busy && (cnt >= CAP_FIRST);
  assign done_entry = busy && (cnt == LAST);
  assign rx_next    = (rx_reg << 1) | WIDTH'(sr_so);

  // tx_sh empties after WIDTH shifts, which gives the trailing zeros that flush the chain.
  always_ff @(posedge clk) begin
    if (!rs) begin
      cnt       <= '0;
      tx_sh     <= '0;
      rx_reg    <= '0;
      sr_si     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      sr_si <= 1'b0;
      if (accept) begin
        cnt    <= CW'(1);
        tx_sh  <= in_data << 1;
        sr_si  <= in_data[WIDTH-1];
        rx_reg <= '0;
      end
      if (busy) begin
        cnt   <= cnt + CW'(1);
        sr_si <= tx_sh[WIDTH-1];
        tx_sh <= tx_sh << 1;
      end
      if (capture) rx_reg <= rx_next;
      if (done_entry) begin
        out_data  <= rx_next;
        out_valid <= 1'b1;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef SISO_LOOPCHK_EN
  logic [WIDTH-1:0] tx_reg;

  // The compare sees the final sample through rx_next, on the same edge that loads out_data.
  always_ff @(posedge clk) begin
    if (!rs) begin
      tx_reg <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) tx_reg <= in_data;
      if (done_entry && (rx_next != tx_reg)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Bench for siso_seq_ctrl: models a DEPTH-stage SISO chain, runs a vector table, hand sequences
// and random words against a "word returns intact after WIDTH+DEPTH cycles" reference.
module tb_siso_seq_ctrl;
  localparam int W   = 4;
  localparam int D   = 4;
  localparam int LAT = W + D;
`ifdef SISO_LOOPCHK_EN
  localparam bit LOOPCHK = 1'b1;
`else
  localparam bit LOOPCHK = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] data;
    int           bp;
    int           bad_k;
    bit           keep;
    logic [W-1:0] exp_out;
  } vec_t;

  logic         clk = 1'b0;
  logic         rs, in_valid, in_ready, sr_si, sr_so, out_valid, out_ready, busy, err;
  logic [W-1:0] in_data, out_data;
  logic [D-1:0] chain;
  logic         corrupt;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_err  = 1'b0;

  always #5 clk = ~clk;

  // External SISO chain, plus a fault injector that forces so high.
  always @(posedge clk) chain <= {chain[D-2:0], sr_si};
  assign sr_so = chain[D-1] | corrupt;

  siso_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rs(rs), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sr_si(sr_si), .sr_so(sr_so), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the word comes back unchanged, except a bit whose capture was forced high.
  function automatic logic [W-1:0] model_out(input logic [W-1:0] w, input int bad_k);
    logic [W-1:0] r;
    r = w;
    if (bad_k >= 0 && bad_k < W) r[W-1-bad_k] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    rs = 1'b0;
    repeat (2) @(negedge clk);
    exp_err = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sr_si", 32'(sr_si), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_data", 32'(out_data), 0);
    rs = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after out_valid is released.
  task automatic xfer(input logic [W-1:0] w, input int bp, input int bad_k, input bit keep,
                      input logic [W-1:0] exp_out);
    int           t;
    logic [W-1:0] sh;
    t         = 0;
    sh        = w;
    in_data   = w;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(in_ready), 1);
    @(negedge clk);
    for (int n = 0; n < LAT; n++) begin
      check("sr_si", 32'(sr_si), 32'(sh[W-1]));
      check("busy", 32'(busy), 1);
      check("in_ready_busy", 32'(in_ready), 0);
      check("out_valid_early", 32'(out_valid), 0);
      sh      = sh << 1;
      corrupt = (bad_k >= 0 && n == bad_k + D);
      @(negedge clk);
    end
    corrupt = 1'b0;
    if (LOOPCHK && exp_out != w) exp_err = 1'b1;
    check("out_valid", 32'(out_valid), 1);
    check("out_data", 32'(out_data), 32'(exp_out));
    check("err", 32'(err), 32'(exp_err));
    check("done_busy", 32'(busy), 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'(exp_out));
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 0);
    check("idle_ready", 32'(in_ready), 1);
    check("idle_busy", 32'(busy), 0);
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    bit   seen;
    logic [W-1:0] w;

    vecs[0] = '{4'b1110, 0, -1, 1'b0, 4'b1110};
    vecs[1] = '{4'b1110, 5, -1, 1'b0, 4'b1110};
    vecs[2] = '{4'b1010, 0, -1, 1'b1, 4'b1010};
    vecs[3] = '{4'b0101, 0, -1, 1'b0, 4'b0101};
    vecs[4] = '{4'b0000, 0, -1, 1'b0, 4'b0000};
    vecs[5] = '{4'b1111, 2, -1, 1'b0, 4'b1111};

    chain     = '0;
    corrupt   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();

    // Nominal, backpressure and back-to-back transfers with in_valid held.
    for (int i = 0; i < 6; i++)
      xfer(vecs[i].data, vecs[i].bp, vecs[i].bad_k, vecs[i].keep, vecs[i].exp_out);

    // Reset during SEND discards the word; the next transfer is unaffected.
    in_data  = 4'b1111;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rs = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_sr_si", 32'(sr_si), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    rs   = 1'b1;
    seen = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 32'(seen), 0);
    xfer(4'b0011, 0, -1, 1'b0, 4'b0011);

    // Random words, backpressure and in_valid holding against the reference.
    for (int i = 0; i < 20; i++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      xfer(w, $urandom_range(0, 3), -1, bit'($urandom_range(0, 1)), model_out(w, -1));
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Forced capture bit: err is raised with the loopback compare and survives a good transfer.
    xfer(4'b0000, 0, 2, 1'b0, model_out(4'b0000, 2));
    xfer(4'b0110, 1, -1, 1'b0, model_out(4'b0110, -1));
    check("err_sticky", 32'(err), 32'(exp_err));
    do_reset();
    xfer(4'b1001, 0, -1, 1'b0, model_out(4'b1001, -1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
